// File: rtl/fib_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fib_ctrl : sequences a 9-entry register file to compute F(n) mod 2^bw
// Revision : 1.0
// ---------------------------------------------------------------------------
module fib_ctrl #(
  parameter int bw = 8,
  parameter int nw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [nw-1:0] n,
  input  logic [bw-1:0] adata,
  input  logic [bw-1:0] bdata,
  output logic [bw-1:0] din,
  output logic          rw,
  output logic [3:0]    da,
  output logic [3:0]    aa,
  output logic [3:0]    ba,
  output logic          busy,
  output logic          done,
  output logic [bw-1:0] result,
  output logic          ovf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_ADD   = 3'd3,
    S_MOV0  = 3'd4,
    S_MOV1  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [nw-1:0] cnt_q, cnt_d;
  logic          f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
  logic          done_q, done_d;
  logic [bw-1:0] result_q, result_d;
  logic          ovf_q, ovf_d;
  logic [bw:0]   sum;

  // f0/f1/f2 track whether r0/r1/r2 hold a value that has wrapped
  assign sum = {1'b0, adata} + {1'b0, bdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f0_q     <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    rw       = 1'b0;
    da       = 4'd0;
    aa       = 4'd0;
    ba       = 4'd0;
    din      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = n;
          state_d = S_INIT0;
        end
      end
      S_INIT0: begin
        rw      = 1'b1;
        f0_d    = 1'b0;
        f1_d    = 1'b0;
        f2_d    = 1'b0;
        state_d = S_INIT1;
      end
      S_INIT1: begin
        rw      = 1'b1;
        da      = 4'd1;
        din     = bw'(1);
        state_d = (cnt_q == '0) ? S_FIN : S_ADD;
      end
      S_ADD: begin
        ba      = 4'd1;
        rw      = 1'b1;
        da      = 4'd2;
        din     = sum[bw-1:0];
        f2_d    = sum[bw] | f0_q | f1_q;
        state_d = S_MOV0;
      end
      S_MOV0: begin
        aa      = 4'd1;
        rw      = 1'b1;
        din     = adata;
        f0_d    = f1_q;
        state_d = S_MOV1;
      end
      S_MOV1: begin
        aa      = 4'd2;
        rw      = 1'b1;
        da      = 4'd1;
        din     = adata;
        f1_d    = f2_q;
        cnt_d   = cnt_q - nw'(1);
        state_d = (cnt_q == nw'(1)) ? S_FIN : S_ADD;
      end
      S_FIN: begin
        result_d = adata;
        ovf_d    = f0_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fib_ctrl : fib_ctrl against a register-file model and a Fibonacci model
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_fib_ctrl;
  localparam int BW = 8;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NW-1:0] n;
  logic [BW-1:0] adata, bdata, din, result;
  logic          rw, busy, done, ovf;
  logic [3:0]    da, aa, ba;

  int ncmp = 0;
  int nfail = 0;
  int wr_cnt = 0;
  logic [BW-1:0] rf [0:8];

  always #5 clk = ~clk;

  fib_ctrl #(.bw(BW), .nw(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .adata(adata), .bdata(bdata), .din(din), .rw(rw), .da(da),
    .aa(aa), .ba(ba), .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  // register file: combinational read, write at the rising edge
  always_comb begin
    adata = (aa < 4'd9) ? rf[aa] : '0;
    bdata = (ba < 4'd9) ? rf[ba] : '0;
  end

  always @(posedge clk) begin
    if (rw) begin
      if (da < 4'd9) rf[da] <= din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // exact value modulo 2^BW plus a capped true value for the wrap flag
  function automatic void ref_fib(input int k, output logic [BW-1:0] r, output logic o);
    longint ta = 0, tb = 1, tn;
    longint ma = 0, mb = 1, mn;
    for (int i = 0; i < k; i++) begin
      tn = ta + tb;
      if (tn > 1000000) tn = 1000000;
      ta = tb; tb = tn;
      mn = (ma + mb) % (longint'(1) << BW);
      ma = mb; mb = mn;
    end
    r = BW'(ma);
    o = (ta >= (longint'(1) << BW));
  endfunction

  // call between edges; returns at the negedge of the done cycle
  task automatic run_one(input logic [NW-1:0] nv, input bit spam,
                         output int dcyc, output int writes, output int bcyc);
    int base;
    start = 1'b1;
    n = nv;
    @(posedge clk);
    #1;
    base = wr_cnt;
    start = spam;
    n = NW'($urandom);
    dcyc = -1;
    bcyc = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        dcyc = c;
        break;
      end
      if (spam) begin
        start = 1'b1;
        n = NW'($urandom);
      end
    end
    start = 1'b0;
    writes = wr_cnt - base;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; n = '0;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({rw, din, da, aa, ba} !== '0) begin
      nfail++;
      $display("FAIL reset_wport: rw/din/da/aa/ba=%h expected 0", {rw, din, da, aa, ba});
    end
    ncmp++;
    if ({busy, done, result, ovf} !== '0) begin
      nfail++;
      $display("FAIL reset_status: busy/done/result/ovf=%h expected 0", {busy, done, result, ovf});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n0();
    int dc, wr, bc;
    run_one(8'd0, 1'b0, dc, wr, bc);
    ncmp++;
    if (dc !== 4) begin nfail++; $display("FAIL n0_latency: got %0d expected 4", dc); end
    ncmp++;
    if ({result, ovf} !== 9'd0) begin nfail++; $display("FAIL n0_result: got %0d/%0d expected 0/0", result, ovf); end
    ncmp++;
    if (rf[0] !== 8'd0 || rf[1] !== 8'd1) begin
      nfail++; $display("FAIL n0_rf: r0=%0d r1=%0d expected 0,1", rf[0], rf[1]);
    end
  endtask

  task automatic test_n10();
    int dc, wr, bc;
    @(negedge clk);
    run_one(8'd10, 1'b0, dc, wr, bc);
    ncmp++;
    if (dc !== 34) begin nfail++; $display("FAIL n10_latency: got %0d expected 34", dc); end
    ncmp++;
    if (result !== 8'd55 || ovf !== 1'b0) begin nfail++; $display("FAIL n10_result: got %0d/%0d expected 55/0", result, ovf); end
    ncmp++;
    if (wr !== 32) begin nfail++; $display("FAIL n10_writes: got %0d expected 32", wr); end
    ncmp++;
    if (bc !== 33) begin nfail++; $display("FAIL n10_busy: got %0d cycles expected 33", bc); end
    @(negedge clk);
    ncmp++;
    if (done !== 1'b0 || result !== 8'd55) begin
      nfail++; $display("FAIL n10_pulse_hold: done=%0d result=%0d expected 0,55", done, result);
    end
  endtask

  task automatic test_overflow();
    int dc, wr, bc;
    @(negedge clk);
    run_one(8'd13, 1'b0, dc, wr, bc);
    ncmp++;
    if (result !== 8'd233 || ovf !== 1'b0) begin nfail++; $display("FAIL n13: got %0d/%0d expected 233/0", result, ovf); end
    @(negedge clk);
    run_one(8'd14, 1'b0, dc, wr, bc);
    ncmp++;
    if (result !== 8'd121 || ovf !== 1'b1) begin nfail++; $display("FAIL n14: got %0d/%0d expected 121/1", result, ovf); end
  endtask

  task automatic test_back_to_back();
    int dc, wr, bc;
    @(negedge clk);
    run_one(8'd1, 1'b0, dc, wr, bc);
    ncmp++;
    if (dc !== 7 || result !== 8'd1) begin nfail++; $display("FAIL b2b_first: cycle=%0d result=%0d expected 7,1", dc, result); end
    run_one(8'd2, 1'b0, dc, wr, bc);
    ncmp++;
    if (dc !== 10 || result !== 8'd1) begin nfail++; $display("FAIL b2b_second: cycle=%0d result=%0d expected 10,1", dc, result); end
  endtask

  task automatic test_start_spam();
    int dc, wr, bc, extra;
    @(negedge clk);
    run_one(8'd5, 1'b1, dc, wr, bc);
    ncmp++;
    if (dc !== 19 || result !== 8'd5) begin nfail++; $display("FAIL spam_result: cycle=%0d result=%0d expected 19,5", dc, result); end
    ncmp++;
    if (wr !== 17) begin nfail++; $display("FAIL spam_writes: got %0d expected 17", wr); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    ncmp++;
    if (extra !== 0) begin nfail++; $display("FAIL spam_restart: %0d active cycles after done, expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int dc, wr, bc, target, diff;
    logic [BW-1:0] snap [0:8];
    @(negedge clk);
    start = 1'b1; n = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    target = 3 + 3 * int'($urandom_range(0, 7));
    repeat (target) @(negedge clk);
    ncmp++;
    if (rw !== 1'b1 || ba !== 4'd1 || da !== 4'd2) begin
      nfail++; $display("FAIL mid_in_add: rw=%0d ba=%0d da=%0d expected 1,1,2", rw, ba, da);
    end
    for (int i = 0; i < 9; i++) snap[i] = rf[i];
    rst = 1'b0;
    #1;
    ncmp++;
    if ({rw, busy, done, result, ovf} !== '0) begin
      nfail++; $display("FAIL mid_abort: rw/busy/done/result/ovf=%h expected 0", {rw, busy, done, result, ovf});
    end
    @(posedge clk);
    #1;
    diff = 0;
    for (int i = 0; i < 9; i++) if (rf[i] !== snap[i]) diff++;
    ncmp++;
    if (diff !== 0) begin nfail++; $display("FAIL mid_no_write: %0d entries changed during reset, expected 0", diff); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_one(8'd8, 1'b0, dc, wr, bc);
    ncmp++;
    if (dc !== 28 || result !== 8'd21 || ovf !== 1'b0) begin
      nfail++; $display("FAIL mid_rerun: cycle=%0d result=%0d ovf=%0d expected 28,21,0", dc, result, ovf);
    end
  endtask

  task automatic test_random();
    int dc, wr, bc, k;
    logic [BW-1:0] er, er1;
    logic eo, eo1;
    for (int t = 0; t < 10; t++) begin
      k = int'($urandom_range(0, 30));
      ref_fib(k, er, eo);
      ref_fib(k + 1, er1, eo1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_one(NW'(k), 1'b0, dc, wr, bc);
      ncmp++;
      if (dc !== 3 * k + 4) begin nfail++; $display("FAIL rand_latency n=%0d: got %0d expected %0d", k, dc, 3 * k + 4); end
      ncmp++;
      if (result !== er || ovf !== eo) begin
        nfail++; $display("FAIL rand_result n=%0d: got %0d/%0d expected %0d/%0d", k, result, ovf, er, eo);
      end
      ncmp++;
      if (rf[1] !== er1 || wr !== 3 * k + 2) begin
        nfail++; $display("FAIL rand_rf n=%0d: r1=%0d writes=%0d expected %0d,%0d", k, rf[1], wr, er1, 3 * k + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_n0();
    test_n10();
    test_overflow();
    test_back_to_back();
    test_start_spam();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
